// File: rtl/flag_branch_unit_if.sv
// ---------------------------------------------------------------------------
// flag_branch_unit_if
// Bundles the EX flag-writer, ID branch and fetch-redirect signals of the
// flag/branch unit so they can travel as one port.
//
//   stall          pipeline freeze
//   ex_valid       EX holds a real instruction
//   ex_flag_we     per-flag write mask {Z,V,N}
//   ex_flag        ALU flags {Z,V,N}
//   id_br_valid    branch present in ID
//   id_br_reg      1 = BR (register target), 0 = B (PC-relative)
//   id_cond        3-bit condition code
//   id_pc_plus2    PC of the branch + 2
//   id_imm         signed word offset for B
//   id_rs_val      register target for BR
//   flags          architectural flag register {Z,V,N}
//   hazard_stall   ID/IF stall request (combinational)
//   redirect_valid one-cycle redirect pulse to fetch
//   redirect_pc    redirect target
//   br_cnt         resolved-branch counter (saturating)
//   taken_cnt      taken-branch counter (saturating)
//
// slave  : the flag/branch unit itself
// master : whoever drives the pipeline side (core or testbench)
// ---------------------------------------------------------------------------
interface flag_branch_unit_if #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
);
    logic             stall;
    logic             ex_valid;
    logic [2:0]       ex_flag_we;
    logic [2:0]       ex_flag;
    logic             id_br_valid;
    logic             id_br_reg;
    logic [2:0]       id_cond;
    logic [PC_W-1:0]  id_pc_plus2;
    logic [IMM_W-1:0] id_imm;
    logic [PC_W-1:0]  id_rs_val;
    logic [2:0]       flags;
    logic             hazard_stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [PC_W-1:0]  br_cnt;
    logic [PC_W-1:0]  taken_cnt;

    modport slave (
        input  stall, ex_valid, ex_flag_we, ex_flag,
        input  id_br_valid, id_br_reg, id_cond, id_pc_plus2, id_imm, id_rs_val,
        output flags, hazard_stall, redirect_valid, redirect_pc, br_cnt, taken_cnt
    );

    modport master (
        output stall, ex_valid, ex_flag_we, ex_flag,
        output id_br_valid, id_br_reg, id_cond, id_pc_plus2, id_imm, id_rs_val,
        input  flags, hazard_stall, redirect_valid, redirect_pc, br_cnt, taken_cnt
    );
endinterface

// File: rtl/flag_branch_unit.sv
// ---------------------------------------------------------------------------
// flag_branch_unit
// Holds the {Z,V,N} flag register written by EX under a per-flag mask,
// evaluates branch conditions for B/BR sitting in ID, and issues a
// registered one-cycle redirect (valid + target) to fetch. A branch that
// reads flags while EX is still writing them is held for one cycle, unless
// flag forwarding is built in. Saturating counters track resolved and
// taken branches.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  flag_branch_unit_if.slave (see the interface file for the list)
//
// Build option:
//   FLAG_FWD_EN  when defined, the condition is evaluated on flags forwarded
//                from EX, so the HOLD cycle never happens and hazard_stall
//                is tied low.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | resolve a branch in ID now, or detect a flag hazard and stall
// HOLD  | EX write has landed in the flag register; resolve the held branch
// ---------------------------------------------------------------------------
module flag_branch_unit #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    flag_branch_unit_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] CNT_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        flags_q, flags_d;
    logic              redirect_valid_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [PC_W-1:0]   br_cnt_q;
    logic [PC_W-1:0]   taken_cnt_q;

    logic              br_act;
    logic              hazard;
    logic              hazard_stall;
    logic              resolve;
    logic              taken;
    logic [2:0]        eval_flags;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   target;

    // Masked flag merge; also the forwarded view of the flags.
    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < 3; i++) begin
            if (bus.ex_valid && bus.ex_flag_we[i]) begin
                flags_d[i] = bus.ex_flag[i];
            end
        end
    end

`ifdef FLAG_FWD_EN
    assign eval_flags = flags_d;
`else
    assign eval_flags = flags_q;
`endif

    // Condition evaluation on {Z,V,N}.
    always_comb begin
        taken = 1'b0;
        case (bus.id_cond)
            3'b000:  taken = ~eval_flags[2];
            3'b001:  taken = eval_flags[2];
            3'b010:  taken = ~eval_flags[2] & ~eval_flags[0];
            3'b011:  taken = eval_flags[0];
            3'b100:  taken = eval_flags[2] | ~eval_flags[0];
            3'b101:  taken = eval_flags[2] | eval_flags[0];
            3'b110:  taken = eval_flags[1];
            default: taken = 1'b1;
        endcase
    end

    // Sign-extended word offset shifted to a byte offset, built directly at
    // PC width so the add below wraps naturally.
    for (genvar gi = 0; gi < PC_W; gi++) begin : g_off
        if (gi == 0) begin : g_lsb
            assign br_off[gi] = 1'b0;
        end else if (gi - 1 < IMM_W) begin : g_imm
            assign br_off[gi] = bus.id_imm[gi-1];
        end else begin : g_sext
            assign br_off[gi] = bus.id_imm[IMM_W-1];
        end
    end

    assign target = bus.id_br_reg ? bus.id_rs_val : (bus.id_pc_plus2 + br_off);

    // A branch seen while the redirect pulse is out is on the wrong path.
    assign br_act = bus.id_br_valid & ~redirect_valid_q;
    assign hazard = br_act & bus.ex_valid & (|bus.ex_flag_we) & (bus.id_cond != 3'b111);

    always_comb begin
        state_d      = state_q;
        hazard_stall = 1'b0;
        resolve      = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef FLAG_FWD_EN
                resolve = br_act;
`else
                if (hazard) begin
                    hazard_stall = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    resolve = br_act;
                end
`endif
            end
            S_HOLD: begin
                resolve = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            flags_q          <= 3'b000;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_cnt_q         <= '0;
            taken_cnt_q      <= '0;
        end else if (!bus.stall) begin
            state_q          <= state_d;
            flags_q          <= flags_d;
            redirect_valid_q <= resolve & taken;
            if (resolve) begin
                redirect_pc_q <= target;
                if (~&br_cnt_q) begin
                    br_cnt_q <= br_cnt_q + CNT_ONE;
                end
                if (taken && ~&taken_cnt_q) begin
                    taken_cnt_q <= taken_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign bus.flags          = flags_q;
    assign bus.hazard_stall   = hazard_stall;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.br_cnt         = br_cnt_q;
    assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    flag_branch_unit_if #(.PC_W(16), .IMM_W(9)) bus ();
    flag_branch_unit_if #(.PC_W(10), .IMM_W(9)) bus2 ();

    flag_branch_unit #(.PC_W(16), .IMM_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    flag_branch_unit #(.PC_W(10), .IMM_W(9)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // {flags ZVN, cond, expected taken}
    localparam logic [6:0] CV [12] = '{
        7'b000_000_1, 7'b100_000_0, 7'b000_010_1, 7'b001_010_0,
        7'b001_011_1, 7'b000_100_1, 7'b001_100_0, 7'b101_100_1,
        7'b001_101_1, 7'b000_101_0, 7'b010_110_1, 7'b000_110_0
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic v, input logic r, input logic [2:0] c,
                          input logic [15:0] pc2, input logic [8:0] imm,
                          input logic [15:0] rs);
        bus.id_br_valid = v;
        bus.id_br_reg   = r;
        bus.id_cond     = c;
        bus.id_pc_plus2 = pc2;
        bus.id_imm      = imm;
        bus.id_rs_val   = rs;
    endtask

    task automatic set_ex(input logic v, input logic [2:0] we, input logic [2:0] f);
        bus.ex_valid   = v;
        bus.ex_flag_we = we;
        bus.ex_flag    = f;
    endtask

    initial begin
        logic [6:0] v;
        bus.stall = 1'b0;
        set_ex(1'b0, 3'b000, 3'b000);
        set_br(1'b0, 1'b0, 3'b000, 16'h0, 9'h0, 16'h0);
        bus2.stall       = 1'b0;
        bus2.ex_valid    = 1'b0;
        bus2.ex_flag_we  = 3'b000;
        bus2.ex_flag     = 3'b000;
        bus2.id_br_valid = 1'b0;
        bus2.id_br_reg   = 1'b0;
        bus2.id_cond     = 3'b001;
        bus2.id_pc_plus2 = 10'h0;
        bus2.id_imm      = 9'h0;
        bus2.id_rs_val   = 10'h0;

        // reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_flags", bus.flags, 3'b000);
        chk("rst_hazard", bus.hazard_stall, 1'b0);
        chk("rst_rv", bus.redirect_valid, 1'b0);
        chk("rst_rpc", bus.redirect_pc, 16'h0);
        chk("rst_br", bus.br_cnt, 16'h0);
        chk("rst_taken", bus.taken_cnt, 16'h0);

        // masked flag writes
        set_ex(1'b1, 3'b111, 3'b100);
        tick();
        chk("flag_all", bus.flags, 3'b100);
        set_ex(1'b1, 3'b001, 3'b001);
        tick();
        chk("flag_mask", bus.flags, 3'b101);

        // B EQ taken, negative offset
        set_ex(1'b1, 3'b001, 3'b000);
        tick();
        set_ex(1'b0, 3'b000, 3'b000);
        chk("flag_clr_n", bus.flags, 3'b100);
        set_br(1'b1, 1'b0, 3'b001, 16'h0010, 9'h1FE, 16'h0);
        #1;
        chk("b_eq_nohaz", bus.hazard_stall, 1'b0);
        tick();
        bus.id_br_valid = 1'b0;
        chk("b_eq_rv", bus.redirect_valid, 1'b1);
        chk("b_eq_rpc", bus.redirect_pc, 16'h000C);
        chk("b_eq_br", bus.br_cnt, 16'd1);
        chk("b_eq_taken", bus.taken_cnt, 16'd1);
        tick();
        chk("pulse_end", bus.redirect_valid, 1'b0);
        chk("rpc_hold", bus.redirect_pc, 16'h000C);

        // BR LT not taken
        set_ex(1'b1, 3'b100, 3'b000);
        tick();
        set_ex(1'b0, 3'b000, 3'b000);
        set_br(1'b1, 1'b1, 3'b011, 16'h0, 9'h0, 16'hBEEF);
        tick();
        bus.id_br_valid = 1'b0;
        chk("br_lt_rv", bus.redirect_valid, 1'b0);
        chk("br_lt_br", bus.br_cnt, 16'd2);
        chk("br_lt_taken", bus.taken_cnt, 16'd1);
        chk("br_lt_rpc", bus.redirect_pc, 16'hBEEF);

        // flag hazard: EX writes Z while ID holds B EQ
        set_ex(1'b1, 3'b100, 3'b100);
        set_br(1'b1, 1'b0, 3'b001, 16'h0020, 9'h002, 16'h0);
        #1;
`ifdef FLAG_FWD_EN
        chk("haz_fwd", bus.hazard_stall, 1'b0);
        tick();
        set_ex(1'b0, 3'b000, 3'b000);
`else
        chk("haz_on", bus.hazard_stall, 1'b1);
        tick();
        set_ex(1'b0, 3'b000, 3'b000);
        #1;
        chk("haz_hold_off", bus.hazard_stall, 1'b0);
        chk("haz_hold_flags", bus.flags, 3'b100);
        chk("haz_hold_rv", bus.redirect_valid, 1'b0);
        tick();
`endif
        chk("haz_rv", bus.redirect_valid, 1'b1);
        chk("haz_rpc", bus.redirect_pc, 16'h0024);
        chk("haz_br", bus.br_cnt, 16'd3);
        chk("haz_taken", bus.taken_cnt, 16'd2);

        // wrong-path branch during the redirect pulse
        set_br(1'b1, 1'b0, 3'b111, 16'h0040, 9'h0, 16'h0);
        tick();
        bus.id_br_valid = 1'b0;
        chk("squash_rv", bus.redirect_valid, 1'b0);
        chk("squash_br", bus.br_cnt, 16'd3);
        chk("squash_rpc", bus.redirect_pc, 16'h0024);

        // reset while a hazard is being held
        set_ex(1'b1, 3'b010, 3'b010);
        set_br(1'b1, 1'b0, 3'b110, 16'h0100, 9'h0, 16'h0);
        #1;
`ifdef FLAG_FWD_EN
        chk("rsthold_haz", bus.hazard_stall, 1'b0);
`else
        chk("rsthold_haz", bus.hazard_stall, 1'b1);
`endif
        tick();
        set_ex(1'b0, 3'b000, 3'b000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.id_br_valid = 1'b0;
        #1;
        chk("rsthold_flags", bus.flags, 3'b000);
        chk("rsthold_hz", bus.hazard_stall, 1'b0);
        chk("rsthold_rv", bus.redirect_valid, 1'b0);
        chk("rsthold_rpc", bus.redirect_pc, 16'h0);
        chk("rsthold_br", bus.br_cnt, 16'h0);
        chk("rsthold_taken", bus.taken_cnt, 16'h0);
        tick();
        chk("rsthold_norv", bus.redirect_valid, 1'b0);

        // condition table
        for (int i = 0; i < 12; i++) begin
            v = CV[i];
            set_ex(1'b1, 3'b111, v[6:4]);
            tick();
            set_ex(1'b0, 3'b000, 3'b000);
            set_br(1'b1, 1'b1, v[3:1], 16'h0, 9'h0, 16'h1234);
            tick();
            bus.id_br_valid = 1'b0;
            chk($sformatf("cond%0d_%03b_%03b", i, v[6:4], v[3:1]), bus.redirect_valid, v[0]);
            tick();
        end
        chk("cond_br", bus.br_cnt, 16'd12);
        chk("cond_taken", bus.taken_cnt, 16'd7);

        // PC wrap
        set_br(1'b1, 1'b0, 3'b111, 16'hFFFE, 9'h0FF, 16'h0);
        tick();
        bus.id_br_valid = 1'b0;
        chk("wrap_rv", bus.redirect_valid, 1'b1);
        chk("wrap_rpc", bus.redirect_pc, 16'h01FC);
        chk("wrap_br", bus.br_cnt, 16'd13);
        tick();

        // stall freezes everything; hazard_stall stays combinational
        bus.stall = 1'b1;
        set_ex(1'b1, 3'b111, 3'b111);
        set_br(1'b1, 1'b0, 3'b111, 16'h0000, 9'h004, 16'h0);
        tick();
        chk("stall_flags", bus.flags, 3'b000);
        chk("stall_br", bus.br_cnt, 16'd13);
        chk("stall_rv", bus.redirect_valid, 1'b0);
        bus.id_cond = 3'b001;
        #1;
`ifdef FLAG_FWD_EN
        chk("stall_haz", bus.hazard_stall, 1'b0);
`else
        chk("stall_haz", bus.hazard_stall, 1'b1);
`endif
        bus.id_cond = 3'b111;
        bus.stall   = 1'b0;
        tick();
        set_ex(1'b0, 3'b000, 3'b000);
        bus.id_br_valid = 1'b0;
        chk("unstall_flags", bus.flags, 3'b111);
        chk("unstall_rv", bus.redirect_valid, 1'b1);
        chk("unstall_rpc", bus.redirect_pc, 16'h0008);
        chk("unstall_br", bus.br_cnt, 16'd14);
        chk("unstall_taken", bus.taken_cnt, 16'd9);

        // counter saturation on the narrow instance (not-taken EQ every cycle)
        bus2.id_br_valid = 1'b1;
        for (int i = 0; i < 1022; i++) tick();
        chk("sat_pre", bus2.br_cnt, 10'd1022);
        tick();
        chk("sat_top", bus2.br_cnt, 10'h3FF);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_stick", bus2.br_cnt, 10'h3FF);
        chk("sat_taken", bus2.taken_cnt, 10'd0);
        chk("sat_rv", bus2.redirect_valid, 1'b0);
        bus2.id_br_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural {Z,V,N} flag register and applies per-flag write masks from EX.
- Evaluates the 3-bit branch condition for B/BR in ID, and issues a registered one-cycle redirect (taken + target) to fetch.
- Detects flag hazards against an in-flight flag writer in EX, and keeps saturating branch and taken-branch counters.

Parameters:
- PC_W, 16, width of PC, target, rs value and counters.
- IMM_W, 9, width of the branch immediate (word offset, sign-extended).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- stall  input  1  global pipeline freeze; holds all state
- ex_valid  input  1  EX holds a real instruction
- ex_flag_we  input  3  per-flag write mask {Z,V,N}
- ex_flag  input  3  ALU flags {Z,V,N}
- id_br_valid  input  1  branch present in ID
- id_br_reg  input  1  1=BR (target rs), 0=B (PC-relative)
- id_cond  input  3  condition code
- id_pc_plus2  input  PC_W  PC of branch + 2
- id_imm  input  IMM_W  signed word offset
- id_rs_val  input  PC_W  register target for BR
- flags  output  3  current flag register {Z,V,N}
- hazard_stall  output  1  request ID/IF stall this cycle
- redirect_valid  output  1  one-cycle redirect pulse
- redirect_pc  output  PC_W  branch target
- br_cnt  output  PC_W  resolved branches, saturating
- taken_cnt  output  PC_W  taken branches, saturating

Behaviour:
- Reset values: flags=3'b000, state=IDLE, hazard_stall=0, redirect_valid=0, redirect_pc=0, br_cnt=0, taken_cnt=0.
- Reset mid-HOLD returns to IDLE with no redirect.
- Flag update (posedge, when !stall & ex_valid): flags[i] <= ex_flag[i] for each i where ex_flag_we[i]=1. Other bits hold.
- Conditions, evaluated on flags F:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 always
- Target:
  - BR: id_rs_val.
  - B: id_pc_plus2 + (sext(id_imm) << 1), modulo 2^PC_W with no overflow detection.
- Hazard: id_br_valid & ex_valid & |ex_flag_we & cond != 111.
- FSM:
  - IDLE, no hazard: resolve now using the flag register.
  - IDLE, hazard: hazard_stall=1 combinationally and go to HOLD.
  - HOLD: ID fields must stay stable (violation is undefined). Resolve using the flag register, which now contains the EX write. hazard_stall=0, then return to IDLE.
- Resolution registers the results: the next cycle has redirect_valid=taken and redirect_pc=target. br_cnt increments; taken_cnt increments if taken. Latency is 1 cycle from resolve to redirect.
- redirect_valid is high for exactly one cycle. redirect_pc holds its last value otherwise.
- Squash: id_br_valid in the cycle redirect_valid=1 is wrong-path. It is ignored: no resolve, no hazard, no count.
- stall=1: no flag write, no FSM transition, no counter change. Registered outputs hold, except redirect_valid is held, not re-pulsed. hazard_stall is still computed from the inputs.
- A flag write and a non-hazard resolve in the same cycle: the write is not visible to this resolve (only reachable with cond=111).
- Counters saturate at all-ones and do not wrap.

Optional Feature:
- FLAG_FWD_EN defined:
  - No HOLD state; hazard_stall tied 0.
  - Resolution uses forwarded flags: bit i = ex_flag_we[i] & ex_valid ? ex_flag[i] : flags[i].
  - Branch latency is always 1 cycle.
- FLAG_FWD_EN undefined: HOLD/stall behaviour as above.

Test Plan:
- Reset, then ex_valid=1, we=111, ex_flag=100 → next cycle flags=100. Then we=001, ex_flag=001 → flags=101.
- flags=100, B cond=001 (EQ), pc_plus2=0x0010, imm=0x1FE (-2) → one cycle later redirect_valid=1, redirect_pc=0x000C; br_cnt=1, taken_cnt=1.
- flags=000, BR cond=011 (LT), rs=0xBEEF → redirect_valid stays 0; br_cnt increments, taken_cnt unchanged.
- Without FLAG_FWD_EN: EX writes Z=1 (we=100) while ID holds B cond=001 → hazard_stall=1 for exactly 1 cycle; next cycle HOLD resolves taken; redirect the cycle after. With FLAG_FWD_EN: hazard_stall=0 and taken in the first cycle.
- Taken redirect pulse with a new id_br_valid cond=111 in the same cycle → no second redirect, br_cnt unchanged. Assert rst during HOLD → state IDLE, all outputs 0.
- pc_plus2=0xFFFE, imm=0x0FF → redirect_pc=0x01FC (wraps). Preload br_cnt near 0xFFFF and resolve → br_cnt sticks at 0xFFFF.
